axo_mem_arbiter: RTL and testbench

//  Shares one unaligned data RAM port between the CPU data port (D) and the CPU

---
 rtl/axo_mem_arb_pkg.sv | 48 ++++
 rtl/axo_mem_req_latch.sv | 29 ++
 rtl/axo_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_axo_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axo_mem_arb_pkg.sv
// axo_mem_arb_pkg
//   Shared definitions for the D/I memory arbiter: FSM state encodings,
//   access-size codes and the latched memory request record.
package axo_mem_arb_pkg;

  // FSM state encodings. The enum carries the same values so waveform viewers
  // and debug code can show symbolic names.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_D = 2'd1;
  localparam logic [1:0] ST_BUSY_I = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    BUSY_D = ST_BUSY_D,
    BUSY_I = ST_BUSY_I
  } arb_state_t;

  // Access size codes on d_asize / m_asize.
  localparam logic [1:0] ASZ_BYTE = 2'd0;
  localparam logic [1:0] ASZ_HALF = 2'd1;
  localparam logic [1:0] ASZ_WORD = 2'd2;

  // One memory request as presented on the m_* port.
  typedef struct packed {
    logic        re;
    logic        we;
    logic [1:0]  asize;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Idle/no-request value: all strobes low, all fields zero.
  localparam mem_req_t MEM_REQ_NONE = '{
    re: 1'b0, we: 1'b0, asize: ASZ_BYTE, addr: 32'd0, wdata: 32'd0
  };

  // Instruction fetches are always word reads at the halfword-aligned address.
  function automatic mem_req_t fetch_req(input logic [30:0] fetch_addr);
    mem_req_t r;
    r.re    = 1'b1;
    r.we    = 1'b0;
    r.asize = ASZ_WORD;
    r.addr  = {fetch_addr, 1'b0};
    r.wdata = 32'd0;
    return r;
  endfunction

endpackage

// File: rtl/axo_mem_req_latch.sv
// axo_mem_req_latch
//   Loadable register holding one mem_req_t, with synchronous clear.
// Ports
//   clk    in   clock
//   rst_n  in   synchronous active-low reset (clears the register)
//   clr    in   synchronous clear (takes priority over load)
//   load   in   capture d at the next edge
//   d      in   request to capture
//   q      out  latched request
module axo_mem_req_latch
  import axo_mem_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clr,
  input  logic     load,
  input  mem_req_t d,
  output mem_req_t q
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      q <= MEM_REQ_NONE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/axo_mem_arbiter.sv
// axo_mem_arbiter
//   Shares one memory port between the CPU data port (D) and the instruction
//   fetch port (I). Fixed priority D > I, except that after STARVE_LIMIT
//   consecutive D grants with I waiting, I is granted. The granted request is
//   latched and held on m_* until the memory signals m_ready.
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   d_re/d_we/d_asize/d_addr/d_wdata   data request in
//   d_rdata/d_ready          data completion out
//   i_re/i_addr              fetch request in (i_addr is a halfword address)
//   i_rdata/i_ready          fetch completion out
//   m_re/m_we/m_asize/m_addr/m_wdata   memory request out (registered)
//   m_rdata/m_ready          memory response in
module axo_mem_arbiter
  import axo_mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_re,
  input  logic        d_we,
  input  logic [1:0]  d_asize,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  input  logic        i_re,
  input  logic [30:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  output logic        m_re,
  output logic        m_we,
  output logic [1:0]  m_asize,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic [3:0] streak;
  logic       d_req;
  logic       starve;
  logic       grant_d;
  logic       grant_i;
  logic       busy;
  logic       done;
  mem_req_t   req_in;
  mem_req_t   req;

  assign d_req   = d_re | d_we;
  // I has waited through STARVE_LIMIT back-to-back D grants: D must yield once.
  assign starve  = i_re && (streak == LIMIT);
  assign grant_d = (state == ST_IDLE) && d_req && !starve;
  assign grant_i = (state == ST_IDLE) && !grant_d && i_re;
  assign busy    = (state == ST_BUSY_D) || (state == ST_BUSY_I);
  // Gating with rst_n keeps a transaction killed by reset from completing.
  assign done    = rst_n && busy && m_ready;

  // Request presented to the latch. A simultaneous read+write from D is
  // treated as a write.
  always_comb begin
    req_in = fetch_req(i_addr);
    if (grant_d) begin
      req_in.re    = d_re & ~d_we;
      req_in.we    = d_we;
      req_in.asize = d_asize;
      req_in.addr  = d_addr;
      req_in.wdata = d_wdata;
    end
  end

  // The latch is cleared on completion, so m_* read back as zero in IDLE
  // without any extra muxing on the outputs.
  axo_mem_req_latch u_latch (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (done),
    .load  (grant_d | grant_i),
    .d     (req_in),
    .q     (req)
  );

  assign m_re    = req.re;
  assign m_we    = req.we;
  assign m_asize = req.asize;
  assign m_addr  = req.addr;
  assign m_wdata = req.wdata;

  assign d_ready = done && (state == ST_BUSY_D);
  assign i_ready = done && (state == ST_BUSY_I);
  // Read data is only meaningful for reads; writes return zero.
  assign d_rdata = (d_ready && req.re) ? m_rdata : 32'd0;
  assign i_rdata = (i_ready && req.re) ? m_rdata : 32'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      streak <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            state <= ST_BUSY_D;
            // Only D grants that overtake a waiting fetch count toward starvation.
            if (i_re) begin
              streak <= (streak >= LIMIT) ? LIMIT : streak + 4'd1;
            end else begin
              streak <= 4'd0;
            end
          end else if (grant_i) begin
            state  <= ST_BUSY_I;
            streak <= 4'd0;
          end
        end
        ST_BUSY_D, ST_BUSY_I: begin
          if (m_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axo_mem_arbiter.sv
// tb_axo_mem_arbiter
//   Directed, table-driven bench for axo_mem_arbiter plus hand-written
//   sequences for reset, wait states, starvation and input changes while busy.
module tb_axo_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_re, d_we;
  logic [1:0]  d_asize;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_ready;
  logic        i_re;
  logic [30:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        m_re, m_we;
  logic [1:0]  m_asize;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axo_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_re    (d_re),
    .d_we    (d_we),
    .d_asize (d_asize),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .i_re    (i_re),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ready (i_ready),
    .m_re    (m_re),
    .m_we    (m_we),
    .m_asize (m_asize),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready)
  );

  typedef struct {
    logic        d_re;
    logic        d_we;
    logic [1:0]  d_asize;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        i_re;
    logic [30:0] i_addr;
    logic [31:0] m_rdata;
    logic        e_re;
    logic        e_we;
    logic [1:0]  e_asize;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_dready;
    logic        e_iready;
    logic [31:0] e_drdata;
    logic [31:0] e_irdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_requests();
    d_re = 1'b0; d_we = 1'b0; i_re = 1'b0; m_ready = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".m_re"},    32'(m_re),    32'd0);
    chk({tag, ".m_we"},    32'(m_we),    32'd0);
    chk({tag, ".d_ready"}, 32'(d_ready), 32'd0);
    chk({tag, ".i_ready"}, 32'(i_ready), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_idle(tag);
    chk({tag, ".m_asize"}, 32'(m_asize), 32'd0);
    chk({tag, ".m_addr"},  m_addr,       32'd0);
    chk({tag, ".m_wdata"}, m_wdata,      32'd0);
    chk({tag, ".d_rdata"}, d_rdata,      32'd0);
    chk({tag, ".i_rdata"}, i_rdata,      32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] streak_m;
    logic       exp_i;

    //                 dre dwe asz addr           wdata          ire iaddr          m_rdata         | re we asz addr           wdata          drdy irdy drdata        irdata
    vecs[0] = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         1'b0, 31'h0,        32'h1234_5678, 1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         1'b1, 1'b0, 32'h1234_5678, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 2'd1, 32'h0000_0202, 32'h0000_BEEF, 1'b0, 31'h0,        32'hAAAA_5555, 1'b0, 1'b1, 2'd1, 32'h0000_0202, 32'h0000_BEEF, 1'b1, 1'b0, 32'h0,         32'h0};
    vecs[2] = '{1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         1'b1, 31'h40,       32'hDEAD_BEEF, 1'b1, 1'b0, 2'd2, 32'h0000_0080, 32'h0,         1'b0, 1'b1, 32'h0,         32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b1, 2'd2, 32'h0000_0300, 32'h1122_3344, 1'b0, 31'h0,        32'h5555_5555, 1'b0, 1'b1, 2'd2, 32'h0000_0300, 32'h1122_3344, 1'b1, 1'b0, 32'h0,         32'h0};
    vecs[4] = '{1'b1, 1'b0, 2'd0, 32'h0000_0003, 32'h0000_00A5, 1'b1, 31'h123,      32'h0000_00C3, 1'b1, 1'b0, 2'd0, 32'h0000_0003, 32'h0000_00A5, 1'b1, 1'b0, 32'h0000_00C3, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         1'b1, 31'h7FFF_FFFF, 32'h0BAD_F00D, 1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         1'b0, 1'b1, 32'h0,         32'h0BAD_F00D};
    vecs[6] = '{1'b1, 1'b0, 2'd1, 32'h0000_1002, 32'h0,         1'b1, 31'h800,      32'h0000_7777, 1'b1, 1'b0, 2'd1, 32'h0000_1002, 32'h0,         1'b1, 1'b0, 32'h0000_7777, 32'h0};

    d_re = 1'b0; d_we = 1'b0; d_asize = 2'd0; d_addr = 32'h0; d_wdata = 32'h0;
    i_re = 1'b0; i_addr = 31'h0; m_rdata = 32'h0; m_ready = 1'b0;

    // 1. Reset held 3 cycles with both requesters active: everything stays zero.
    rst_n = 1'b0;
    d_re = 1'b1; d_addr = 32'h0000_0044; d_asize = 2'd2;
    i_re = 1'b1; i_addr = 31'h0000_0100;
    m_ready = 1'b1; m_rdata = 32'h9999_9999;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_all_zero($sformatf("reset_c%0d", c));
    end
    rst_n = 1'b1;
    step();
    chk("reset_first_grant.d_ready", 32'(d_ready), 32'd1);
    chk("reset_first_grant.i_ready", 32'(i_ready), 32'd0);
    chk("reset_first_grant.m_addr",  m_addr,       32'h0000_0044);
    $display("txn reset: first grant after release went to %s", d_ready ? "D" : "I");
    step();
    drop_requests();
    do_reset();

    // Table-driven single transactions with a zero-wait memory.
    for (int v = 0; v < 7; v++) begin
      d_re = vecs[v].d_re; d_we = vecs[v].d_we; d_asize = vecs[v].d_asize;
      d_addr = vecs[v].d_addr; d_wdata = vecs[v].d_wdata;
      i_re = vecs[v].i_re; i_addr = vecs[v].i_addr;
      m_ready = 1'b0;
      step();
      m_ready = 1'b1; m_rdata = vecs[v].m_rdata;
      #1;
      chk($sformatf("vec%0d.m_re", v),    32'(m_re),    32'(vecs[v].e_re));
      chk($sformatf("vec%0d.m_we", v),    32'(m_we),    32'(vecs[v].e_we));
      chk($sformatf("vec%0d.m_asize", v), 32'(m_asize), 32'(vecs[v].e_asize));
      chk($sformatf("vec%0d.m_addr", v),  m_addr,       vecs[v].e_addr);
      chk($sformatf("vec%0d.m_wdata", v), m_wdata,      vecs[v].e_wdata);
      chk($sformatf("vec%0d.d_ready", v), 32'(d_ready), 32'(vecs[v].e_dready));
      chk($sformatf("vec%0d.i_ready", v), 32'(i_ready), 32'(vecs[v].e_iready));
      chk($sformatf("vec%0d.d_rdata", v), d_rdata,      vecs[v].e_drdata);
      chk($sformatf("vec%0d.i_rdata", v), i_rdata,      vecs[v].e_irdata);
      $display("txn vec%0d: m_addr=0x%08h re=%0b we=%0b d_ready=%0b i_ready=%0b",
               v, m_addr, m_re, m_we, d_ready, i_ready);
      step();
      drop_requests();
      #1;
      chk_idle($sformatf("vec%0d_idle", v));
      chk($sformatf("vec%0d_idle.m_addr", v), m_addr, 32'd0);
    end

    // m_ready high while idle must not produce a ready pulse.
    m_ready = 1'b1;
    #1;
    chk_idle("idle_mready");
    step();
    chk_idle("idle_mready2");
    m_ready = 1'b0;

    // 3. Write with three wait states: outputs held, d_ready only on m_ready.
    d_we = 1'b1; d_addr = 32'h0000_00FF; d_asize = 2'd0; d_wdata = 32'h0000_0041;
    step();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("wait_c%0d.m_we", c),    32'(m_we),    32'd1);
      chk($sformatf("wait_c%0d.m_addr", c),  m_addr,       32'h0000_00FF);
      chk($sformatf("wait_c%0d.m_wdata", c), m_wdata,      32'h0000_0041);
      chk($sformatf("wait_c%0d.m_asize", c), 32'(m_asize), 32'd0);
      chk($sformatf("wait_c%0d.d_ready", c), 32'(d_ready), 32'd0);
      step();
    end
    m_ready = 1'b1; m_rdata = 32'hFFFF_FFFF;
    #1;
    chk("wait_done.d_ready", 32'(d_ready), 32'd1);
    chk("wait_done.d_rdata", d_rdata,      32'd0);
    chk("wait_done.m_we",    32'(m_we),    32'd1);
    $display("txn write_wait: d_ready=%0b d_rdata=0x%08h", d_ready, d_rdata);
    step();
    drop_requests();

    // 4. Starvation: both held, zero-wait memory, limit 4.
    do_reset();
    d_re = 1'b1; d_we = 1'b0; d_asize = 2'd2; d_addr = 32'h0000_0D00;
    i_re = 1'b1; i_addr = 31'h0000_0700;
    m_ready = 1'b1; m_rdata = 32'h0000_1234;
    streak_m = 4'd0;
    for (int g = 0; g < 10; g++) begin
      exp_i = (streak_m == 4'd4);
      streak_m = exp_i ? 4'd0 : streak_m + 4'd1;
      step();
      chk($sformatf("starve_g%0d.i_ready", g), 32'(i_ready), 32'(exp_i));
      chk($sformatf("starve_g%0d.d_ready", g), 32'(d_ready), 32'(!exp_i));
      chk($sformatf("starve_g%0d.m_addr", g),  m_addr, exp_i ? 32'h0000_0E00 : 32'h0000_0D00);
      $display("txn starve grant %0d: %s", g, i_ready ? "I" : (d_ready ? "D" : "-"));
      step();
    end
    drop_requests();

    // 5. Reset while a fetch waits on memory: dropped, then retried cleanly.
    do_reset();
    i_re = 1'b1; i_addr = 31'h0000_0010;
    step();
    chk("midrst_busy.m_re",    32'(m_re),    32'd1);
    chk("midrst_busy.i_ready", 32'(i_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_low.i_ready", 32'(i_ready), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk_all_zero("midrst_after");
    step();
    m_ready = 1'b1; m_rdata = 32'hCAFE_F00D;
    #1;
    chk("midrst_retry.i_ready", 32'(i_ready), 32'd1);
    chk("midrst_retry.i_rdata", i_rdata,      32'hCAFE_F00D);
    chk("midrst_retry.m_addr",  m_addr,       32'h0000_0020);
    $display("txn reset_midflight: retry i_ready=%0b i_rdata=0x%08h", i_ready, i_rdata);
    step();
    drop_requests();

    // 6. Requester address changes while busy: latched address is held.
    d_re = 1'b1; d_asize = 2'd2; d_addr = 32'h0000_0010;
    step();
    chk("chg_c0.m_addr", m_addr, 32'h0000_0010);
    d_addr = 32'h0000_0020;
    step();
    chk("chg_c1.m_addr", m_addr, 32'h0000_0010);
    step();
    chk("chg_c2.m_addr", m_addr, 32'h0000_0010);
    m_ready = 1'b1; m_rdata = 32'h0000_5A5A;
    #1;
    chk("chg_done.d_ready", 32'(d_ready), 32'd1);
    chk("chg_done.m_addr",  m_addr,       32'h0000_0010);
    chk("chg_done.d_rdata", d_rdata,      32'h0000_5A5A);
    $display("txn input_change: m_addr=0x%08h d_ready=%0b", m_addr, d_ready);
    step();
    drop_requests();
    #1;
    chk_idle("chg_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
